// File: rtl/sweep_sequencer.sv
// sweep_sequencer: triangle-sweep controller driving an up/down counter's set/enable/direction pins.
// Define SWEEP_SEQUENCER_PAUSE_EN to add a pause input that freezes stepping in UP/DOWN.
module sweep_sequencer #(
   parameter int CW = 4,
   parameter int PW = 8,
   parameter int NW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
`ifdef SWEEP_SEQUENCER_PAUSE_EN
   input  logic          pause,
`endif
   input  logic [CW-1:0] lo,
   input  logic [CW-1:0] hi,
   input  logic [PW-1:0] prescale,
   input  logic [NW-1:0] n_sweeps,
   output logic          cnt_set,
   output logic [CW-1:0] cnt_set_value,
   output logic          cnt_enable,
   output logic          cnt_up,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [NW-1:0] sweep_cnt
);
   typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;
   state_t        state_q;
   logic [CW-1:0] lo_q, hi_q, pos_q, set_val_q;
   logic [PW-1:0] ps_q, pc_q;
   logic [NW-1:0] n_q, sc_q, sc_d;
   logic          set_q, en_q, up_q, busy_q, done_q, err_q;
   logic          tick, hold;
   assign tick = pc_q == ps_q;
   assign sc_d = sc_q + NW'(1);
`ifdef SWEEP_SEQUENCER_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         lo_q      <= '0;
         hi_q      <= '0;
         pos_q     <= '0;
         set_val_q <= '0;
         ps_q      <= '0;
         pc_q      <= '0;
         n_q       <= '0;
         sc_q      <= '0;
         set_q     <= 1'b0;
         en_q      <= 1'b0;
         up_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         set_q  <= 1'b0;
         en_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (start) begin
                  if (lo < hi) begin
                     lo_q      <= lo;
                     hi_q      <= hi;
                     ps_q      <= prescale;
                     n_q       <= n_sweeps;
                     sc_q      <= '0;
                     pos_q     <= lo;
                     set_q     <= 1'b1;
                     set_val_q <= lo;
                     busy_q    <= 1'b1;
                     state_q   <= LOAD;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               LOAD: begin
                  state_q <= UP;
                  up_q    <= 1'b1;
                  pc_q    <= '0;
               end
               UP, DOWN: if (!hold) begin
                  if (!tick) begin
                     pc_q <= pc_q + 1'b1;
                  end else begin
                     pc_q <= '0;
                     // a tick at a bound is spent as a dwell, not a step
                     if (state_q == UP) begin
                        if (pos_q != hi_q) begin
                           en_q  <= 1'b1;
                           pos_q <= pos_q + 1'b1;
                        end else begin
                           state_q <= DOWN;
                           up_q    <= 1'b0;
                        end
                     end else if (pos_q != lo_q) begin
                        en_q  <= 1'b1;
                        pos_q <= pos_q - 1'b1;
                     end else begin
                        sc_q <= sc_d;
                        if (n_q != '0 && sc_d == n_q) begin
                           state_q <= DONE;
                           done_q  <= 1'b1;
                        end else begin
                           state_q <= UP;
                           up_q    <= 1'b1;
                        end
                     end
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign cnt_set       = set_q;
   assign cnt_set_value = set_val_q;
   assign cnt_enable    = en_q;
   assign cnt_up        = up_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;
   assign sweep_cnt     = sc_q;
endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed scoreboard bench; a negedge monitor pops expected counter-pin events.
module tb_sweep_sequencer;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       pause = 1'b0;
   logic [3:0] lo = '0, hi = '0, n_sweeps = '0;
   logic [7:0] prescale = '0;
   logic       cnt_set, cnt_enable, cnt_up, busy, done, err;
   logic [3:0] cnt_set_value, sweep_cnt;

   sweep_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef SWEEP_SEQUENCER_PAUSE_EN
      .pause(pause),
`endif
      .lo(lo), .hi(hi), .prescale(prescale), .n_sweeps(n_sweeps),
      .cnt_set(cnt_set), .cnt_set_value(cnt_set_value), .cnt_enable(cnt_enable),
      .cnt_up(cnt_up), .busy(busy), .done(done), .err(err), .sweep_cnt(sweep_cnt)
   );

   always #5 clk = ~clk;

   localparam int K_SET = 0, K_EN = 1, K_DONE = 2, K_ERR = 3;
   typedef struct {int kind; int val; int up; int gap;} ev_t;
   ev_t exp_q[$];
   int  ncmp = 0, nfail = 0;
   int  since = 0, cval = 0;

   task automatic chk(input string name, input int act, input int req);
      ncmp++;
      if (act != req) begin
         nfail++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic push(input int k, input int v, input int u, input int g);
      ev_t e;
      e.kind = k; e.val = v; e.up = u; e.gap = g;
      exp_q.push_back(e);
   endtask

   // one full run: set, then per sweep (hi-lo) up steps and (hi-lo) down steps
   task automatic push_run(input int l, input int h, input int p, input int sweeps, input bit with_done);
      int t = p + 1;
      push(K_SET, l, 0, -1);
      for (int s = 0; s < sweeps; s++) begin
         for (int k = 1; k <= h - l; k++) push(K_EN, l + k, 1, k > 1 ? t : (s == 0 ? 2 + p : 2 * t));
         for (int k = 1; k <= h - l; k++) push(K_EN, h - k, 0, k > 1 ? t : 2 * t);
      end
      if (with_done) push(K_DONE, sweeps, 0, t);
   endtask

   task automatic observe(input int k, input int v, input int u);
      ev_t e;
      if (exp_q.size() == 0) begin
         ncmp++;
         nfail++;
         $display("FAIL unexpected_event: got kind %0d value %0d, required no event", k, v);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", k, e.kind);
         chk("event_value", v, e.val);
         if (k == K_EN) chk("step_direction", u, e.up);
         if (e.gap >= 0) chk("event_spacing", since, e.gap);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         since++;
         if (err) observe(K_ERR, 0, 0);
         if (cnt_set) begin
            cval = int'(cnt_set_value);
            observe(K_SET, cval, 0);
         end
         if (cnt_enable) begin
            cval = cnt_up ? cval + 1 : cval - 1;
            observe(K_EN, cval, int'(cnt_up));
         end
         if (done) observe(K_DONE, int'(sweep_cnt), 0);
         if (err || cnt_set || cnt_enable || done) since = 0;
      end
   end

   task automatic go(input int l, input int h, input int p, input int n);
      @(negedge clk);
      lo = 4'(l); hi = 4'(h); prescale = 8'(p); n_sweeps = 4'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int req_cnt);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = done;
      end
      chk("done_seen", int'(seen), 1);
      if (seen) begin
         chk("busy_at_done", int'(busy), 1);
         @(negedge clk);
         chk("busy_after_done", int'(busy), 0);
         chk("sweep_cnt_final", int'(sweep_cnt), req_cnt);
      end
   endtask

   task automatic wait_up(input bit lvl, input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         seen = cnt_up == lvl;
      end
      chk("direction_reached", int'(seen), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_cnt_set", int'(cnt_set), 0);
      chk("reset_cnt_up", int'(cnt_up), 0);
      chk("reset_sweep_cnt", int'(sweep_cnt), 0);
      rst_n = 1'b1;

      // basic sweep; inputs scrambled and start re-pulsed while busy must be ignored
      push_run(2, 5, 0, 1, 1);
      go(2, 5, 0, 1);
      lo = 4'd9; hi = 4'd1; prescale = 8'd7; n_sweeps = 4'd0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(50, 1);
      chk("basic_drained", exp_q.size(), 0);

      push_run(0, 1, 3, 1, 1);
      go(0, 1, 3, 1);
      wait_done(100, 1);
      chk("prescale_drained", exp_q.size(), 0);

      push(K_ERR, 0, 0, -1);
      go(7, 7, 0, 1);
      repeat (3) @(negedge clk);
      chk("reject_equal_busy", int'(busy), 0);
      push(K_ERR, 0, 0, -1);
      go(9, 3, 0, 1);
      repeat (3) @(negedge clk);
      chk("reject_inverted_busy", int'(busy), 0);
      chk("reject_drained", exp_q.size(), 0);

      // continuous: abort lands on the first up tick after the 5th sweep, so no 6th-sweep step
      push_run(0, 15, 0, 5, 0);
      go(0, 15, 0, 0);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            seen = sweep_cnt == 4'd5;
         end
         chk("continuous_sweep_cnt", int'(sweep_cnt), 5);
      end
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("continuous_abort_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      chk("continuous_drained", exp_q.size(), 0);

      push(K_SET, 2, 0, -1);
      push(K_EN, 3, 1, 2);
      go(2, 5, 0, 1);
      @(negedge clk);
      @(negedge clk) abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      repeat (5) @(negedge clk);
      chk("abort_drained", exp_q.size(), 0);
      chk("abort_sweep_cnt", int'(sweep_cnt), 0);
      push_run(2, 5, 0, 1, 1);
      go(2, 5, 0, 1);
      wait_done(50, 1);

      // reset asserted mid-cycle during the top dwell of DOWN entry
      push(K_SET, 2, 0, -1);
      push(K_EN, 3, 1, 2);
      push(K_EN, 4, 1, 1);
      push(K_EN, 5, 1, 1);
      go(2, 5, 0, 1);
      wait_up(1'b1, 20);
      wait_up(1'b0, 20);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_busy", int'(busy), 0);
      chk("async_reset_set_value", int'(cnt_set_value), 0);
      chk("async_reset_outputs", int'({cnt_set, cnt_enable, cnt_up, done, err}), 0);
      chk("async_reset_sweep_cnt", int'(sweep_cnt), 0);
      chk("reset_run_drained", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      push_run(2, 5, 0, 1, 1);
      go(2, 5, 0, 1);
      wait_done(50, 1);

      repeat (3) @(negedge clk);
      chk("final_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
